// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: access sizes, trap causes, memory-stage FSM
// states and the data-bus request payload.
package pipeline_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned STRB_W      = XLEN / 8;
  localparam int unsigned ECAUSE_W    = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [ECAUSE_W-1:0] ECAUSE_ILLEGAL_INSTR     = 4'd2;
  localparam logic [ECAUSE_W-1:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [ECAUSE_W-1:0] ECAUSE_STORE_MISALIGNED = 4'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ma_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   address;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] strobe;
    logic              write;
  } mem_bus_t;

  // Natural alignment check; the reserved size code behaves like a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~lo[0];
      default:   is_aligned = (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] strobe_for(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: strobe_for = 4'b0001 << lo;
      SIZE_HALF: strobe_for = 4'b0011 << lo;
      default:   strobe_for = 4'b1111;
    endcase
  endfunction

  // Store data is copied into every lane so the strobes alone pick the bytes.
  function automatic logic [XLEN-1:0] replicate_store(input logic [1:0] size, input logic [XLEN-1:0] data);
    case (size)
      SIZE_BYTE: replicate_store = {4{data[7:0]}};
      SIZE_HALF: replicate_store = {2{data[15:0]}};
      default:   replicate_store = data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load result formatting: shift the addressed bytes down, truncate to the
// access size, then sign- or zero-extend.
module load_align
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  output logic [XLEN-1:0] data_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: data_c = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_c = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   data_c = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues one data-bus transaction per aligned load/store,
// flags misaligned accesses, and forwards the instruction to writeback.
module memory_access
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] alu_addition_in,
  input  logic [31:0]           alu_data_in,
  input  logic [31:0]           rs2_data_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic [1:0]            load_store_size_in,
  input  logic                  load_signed_in,
  input  logic                  bypass_memory_in,
  input  logic                  exception_in,
  input  logic [3:0]            ecause_in,
  input  logic [31:0]           pc_in,
  input  logic [31:0]           next_pc_in,
  input  logic [31:0]           csr_data_in,
  input  logic [1:0]            write_select_in,
  input  logic [4:0]            rd_address_in,
  input  logic [11:0]           csr_address_in,
  input  logic                  csr_write_in,
  input  logic                  mret_in,
  input  logic                  wfi_in,
  input  logic                  stall,
  input  logic                  invalidate,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_strobe,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_busy,
  output logic                  valid_out,
  output logic [31:0]           load_data_out,
  output logic                  exception_out,
  output logic [3:0]            ecause_out,
  output logic [31:0]           alu_data_out,
  output logic [31:0]           pc_out,
  output logic [31:0]           next_pc_out,
  output logic [31:0]           csr_data_out,
  output logic [1:0]            write_select_out,
  output logic [4:0]            rd_address_out,
  output logic [11:0]           csr_address_out,
  output logic                  csr_write_out,
  output logic                  mret_out,
  output logic                  wfi_out
);

  ma_state_e     state_q, state_d;
  mem_bus_t      bus_q, bus_d;
  logic          kill_q, kill_d;
  logic          valid_d, exc_d, req_d;
  logic [3:0]    ecause_d;
  logic [31:0]   ld_d, load_data_c;
  logic [1:0]    op_lo_q, op_size_q;
  logic          op_signed_q;
  logic          ls_c, aligned_c, misalign_c, bus_op_c, start_c, capture_c;

  always_comb begin
    ls_c       = valid_in && (load_in || store_in);
    aligned_c  = is_aligned(load_store_size_in, alu_addition_in[1:0]);
    misalign_c = ls_c && !exception_in && !aligned_c;
    bus_op_c   = ls_c && !exception_in && !bypass_memory_in && aligned_c;
    capture_c  = (state_q == ST_IDLE) && !stall;
    start_c    = capture_c && !invalidate && bus_op_c;
  end

  load_align u_load_align (
    .rdata    (mem_rdata),
    .addr_lo  (op_lo_q),
    .size     (op_size_q),
    .sign_ext (op_signed_q),
    .data_c   (load_data_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_c)   state_d = ST_WAIT;
      ST_WAIT: if (mem_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Next values for all registered outputs; everything holds by default.
  always_comb begin
    valid_d  = valid_out;
    exc_d    = exception_out;
    ecause_d = ecause_out;
    kill_d   = kill_q;
    bus_d    = bus_q;
    ld_d     = load_data_out;
    unique case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (!stall) begin
          valid_d  = valid_in && !bus_op_c;
          exc_d    = exception_in || misalign_c;
          ecause_d = misalign_c ? (load_in ? ECAUSE_LOAD_MISALIGNED : ECAUSE_STORE_MISALIGNED)
                                : ecause_in;
          if (start_c) begin
            bus_d.address = {alu_addition_in[ADDR_WIDTH-1:2], 2'b00};
            bus_d.wdata   = replicate_store(load_store_size_in, rs2_data_in);
            bus_d.strobe  = strobe_for(load_store_size_in, alu_addition_in[1:0]);
            bus_d.write   = store_in;
          end
        end
        if (invalidate) valid_d = 1'b0;
      end
      ST_WAIT: begin
        // A flush during the transaction lets the bus finish but drops the result.
        kill_d = kill_q || invalidate;
        if (mem_ready) begin
          valid_d = !(kill_q || invalidate);
          ld_d    = load_data_c;
          kill_d  = 1'b0;
        end
      end
      default: ;
    endcase
    req_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out     <= 1'b0;
      exception_out <= 1'b0;
      ecause_out    <= '0;
      kill_q        <= 1'b0;
      bus_q         <= '0;
      load_data_out <= '0;
      mem_req       <= 1'b0;
      mem_busy      <= 1'b0;
    end else begin
      valid_out     <= valid_d;
      exception_out <= exc_d;
      ecause_out    <= ecause_d;
      kill_q        <= kill_d;
      bus_q         <= bus_d;
      load_data_out <= ld_d;
      mem_req       <= req_d;
      mem_busy      <= req_d;
    end
  end

  // Payload registers are qualified by valid_out and need no reset.
  always_ff @(posedge clk) begin
    if (capture_c) begin
      alu_data_out     <= alu_data_in;
      pc_out           <= pc_in;
      next_pc_out      <= next_pc_in;
      csr_data_out     <= csr_data_in;
      write_select_out <= write_select_in;
      rd_address_out   <= rd_address_in;
      csr_address_out  <= csr_address_in;
      csr_write_out    <= csr_write_in;
      mret_out         <= mret_in;
      wfi_out          <= wfi_in;
      op_lo_q          <= alu_addition_in[1:0];
      op_size_q        <= load_store_size_in;
      op_signed_q      <= load_signed_in;
    end
  end

  assign mem_address = bus_q.address;
  assign mem_wdata   = bus_q.wdata;
  assign mem_strobe  = bus_q.strobe;
  assign mem_write   = bus_q.write;

endmodule

// File: tb/tb_memory_access.sv
// Randomized self-checking bench for memory_access against a transaction-level model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_addition_in, alu_data_in, rs2_data_in;
  logic        load_in, store_in;
  logic [1:0]  load_store_size_in;
  logic        load_signed_in, bypass_memory_in, exception_in;
  logic [3:0]  ecause_in;
  logic [31:0] pc_in, next_pc_in, csr_data_in;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in;
  logic        stall, invalidate;
  logic        mem_req, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_strobe;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_busy, valid_out;
  logic [31:0] load_data_out;
  logic        exception_out;
  logic [3:0]  ecause_out;
  logic [31:0] alu_data_out, pc_out, next_pc_out, csr_data_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic        csr_write_out, mret_out, wfi_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_valid;

  memory_access #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .alu_addition_in(alu_addition_in), .alu_data_in(alu_data_in), .rs2_data_in(rs2_data_in),
    .load_in(load_in), .store_in(store_in), .load_store_size_in(load_store_size_in),
    .load_signed_in(load_signed_in), .bypass_memory_in(bypass_memory_in),
    .exception_in(exception_in), .ecause_in(ecause_in),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .csr_data_in(csr_data_in),
    .write_select_in(write_select_in), .rd_address_in(rd_address_in),
    .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .stall(stall), .invalidate(invalidate),
    .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .valid_out(valid_out),
    .load_data_out(load_data_out), .exception_out(exception_out), .ecause_out(ecause_out),
    .alu_data_out(alu_data_out), .pc_out(pc_out), .next_pc_out(next_pc_out),
    .csr_data_out(csr_data_out), .write_select_out(write_select_out),
    .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
    .csr_write_out(csr_write_out), .mret_out(mret_out), .wfi_out(wfi_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Expected load value: pick bytes arithmetically, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int lo,
                                             input int nb, input logic sgn);
    logic [31:0] v, mask;
    v = rdata >> (8 * lo);
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v = v & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] data, input int nb);
    logic [31:0] w, d;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      d = data >> (8 * (k % nb));
      w[8*k +: 8] = d[7:0];
    end
    return w;
  endfunction

  task automatic idle_inputs();
    valid_in = 0; alu_addition_in = 0; alu_data_in = 0; rs2_data_in = 0;
    load_in = 0; store_in = 0; load_store_size_in = 0; load_signed_in = 0;
    bypass_memory_in = 0; exception_in = 0; ecause_in = 0; pc_in = 0; next_pc_in = 0;
    csr_data_in = 0; write_select_in = 0; rd_address_in = 0; csr_address_in = 0;
    csr_write_in = 0; mret_in = 0; wfi_in = 0; stall = 0; invalidate = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  // One instruction through the stage: optional stall cycles, accept, bus wait, completion.
  task automatic txn(input logic [31:0] addr, input logic [31:0] rs2, input int op,
                     input logic [1:0] size, input logic sgn, input logic byp,
                     input logic exc, input logic [3:0] ec, input logic vld,
                     input int stalls, input logic inv_acc, input int waits,
                     input logic [31:0] rdata, input int inv_at);
    int nb, lo;
    logic aligned, ls, bus, mis, killed;
    logic [31:0] pc, alu;
    logic [3:0] strb;
    nb = size_bytes(size);
    lo = int'(addr[1:0]);
    aligned = (lo % nb) == 0;
    ls  = vld && (op != 0);
    bus = ls && !exc && !byp && aligned;
    mis = ls && !exc && !aligned;
    pc  = $urandom; alu = $urandom;
    valid_in = vld; alu_addition_in = addr; alu_data_in = alu; rs2_data_in = rs2;
    load_in = (op == 1); store_in = (op == 2); load_store_size_in = size;
    load_signed_in = sgn; bypass_memory_in = byp; exception_in = exc; ecause_in = ec;
    pc_in = pc; next_pc_in = pc + 32'd4; csr_data_in = $urandom;
    rd_address_in = 5'($urandom); write_select_in = 2'($urandom);
    for (int i = 0; i < stalls; i++) begin
      stall = 1; invalidate = ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
      if (invalidate) exp_valid = 0;
      check("stall_valid", valid_out, exp_valid);
      check("stall_req", mem_req, 0);
    end
    stall = 0; invalidate = inv_acc;
    @(posedge clk); #1;
    invalidate = 0;
    if (inv_acc) begin
      check("inv_valid", valid_out, 0);
      check("inv_req", mem_req, 0);
      exp_valid = 0;
    end else if (bus) begin
      strb = 4'(((1 << nb) - 1) << lo);
      check("issue_req", mem_req, 1);
      check("issue_busy", mem_busy, 1);
      check("issue_valid", valid_out, 0);
      check("issue_addr", mem_address, addr & 32'hFFFF_FFFC);
      check("issue_strobe", mem_strobe, strb);
      check("issue_write", mem_write, op == 2);
      if (op == 2) check("issue_wdata", mem_wdata, model_wdata(rs2, nb));
      killed = 0;
      for (int i = 0; i < waits; i++) begin
        valid_in = 1'($urandom); alu_addition_in = $urandom; rs2_data_in = $urandom;
        load_in = 1'($urandom); store_in = 1'($urandom); stall = 1'($urandom);
        load_store_size_in = 2'($urandom); invalidate = (i == inv_at); mem_ready = 0;
        @(posedge clk); #1;
        if (invalidate) killed = 1;
        invalidate = 0;
        check("wait_busy", mem_busy, 1);
        check("wait_req", mem_req, 1);
        check("wait_addr", mem_address, addr & 32'hFFFF_FFFC);
        check("wait_strobe", mem_strobe, strb);
        check("wait_valid", valid_out, 0);
      end
      invalidate = (inv_at == waits); mem_ready = 1; mem_rdata = rdata;
      @(posedge clk); #1;
      if (invalidate) killed = 1;
      invalidate = 0; mem_ready = 0;
      check("done_valid", valid_out, !killed);
      check("done_req", mem_req, 0);
      check("done_busy", mem_busy, 0);
      if (op == 1) check("load_data", load_data_out, model_load(rdata, lo, nb, sgn));
      exp_valid = !killed;
    end else begin
      check("pass_valid", valid_out, vld);
      check("pass_exc", exception_out, exc || mis);
      if (exc) check("pass_ecause", ecause_out, ec);
      else if (mis) check("mis_ecause", ecause_out, (op == 1) ? 4 : 6);
      check("pass_pc", pc_out, pc);
      check("pass_npc", next_pc_out, pc + 32'd4);
      check("pass_alu", alu_data_out, alu);
      check("pass_req", mem_req, 0);
      exp_valid = vld;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_busy", mem_busy, 0);
    check("rst_exc", exception_out, 0);
    check("rst_ecause", ecause_out, 0);
    check("rst_strobe", mem_strobe, 0);
    check("rst_write", mem_write, 0);
    check("rst_ldata", load_data_out, 0);
    reset = 0;
    exp_valid = 0;

    // Signed byte load from the top lane.
    txn(32'h0000_1003, 0, 1, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0, 32'h80AA_BBCC, -1);
    check("lb_value", load_data_out, 32'hFFFF_FF80);
    // Halfword store to the upper half.
    txn(32'h0000_2002, 32'h0000_BEEF, 2, 2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 0, -1);
    // Misaligned word load traps without a bus request.
    txn(32'h0000_3001, 0, 1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1);
    // Long wait with a flush in the third WAIT cycle.
    txn(32'h0000_4000, 0, 1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 5, 32'h1234_5678, 2);
    // ALU ops with stalls; upstream exception overrides misalignment.
    txn(32'h0000_5000, 0, 0, 2'b10, 0, 0, 0, 0, 1, 2, 0, 0, 0, -1);
    txn(32'h0000_5001, 0, 2, 2'b10, 0, 0, 1, 4'd2, 1, 1, 0, 0, 0, -1);
    txn(32'h0000_5006, 0, 2, 2'b01, 0, 0, 0, 0, 1, 1, 0, 0, 0, -1);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [1:0] sz;
      int w, ia;
      a  = $urandom;
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      w  = $urandom_range(0, 3);
      ia = ($urandom_range(0, 4) == 0) ? $urandom_range(0, w) : -1;
      txn(a, $urandom, $urandom_range(0, 2), sz, 1'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 7) != 0,
          $urandom_range(0, 2), $urandom_range(0, 9) == 0, w, $urandom, ia);
    end

    // Reset in the middle of a transaction drops the request.
    idle_inputs();
    valid_in = 1; load_in = 1; load_store_size_in = 2'b10; alu_addition_in = 32'h0000_6000;
    @(posedge clk); #1;
    check("mid_req", mem_req, 1);
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midrst_req", mem_req, 0);
    check("midrst_busy", mem_busy, 0);
    check("midrst_valid", valid_out, 0);
    @(posedge clk); #1;
    check("post_rst_req", mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, data-bus address width (only 32 supported).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  execute-stage slot holds a live instruction.
REQ-005 SHALL have port alu_addition_in  input  32  effective address for load/store.
REQ-006 SHALL have port alu_data_in  input  32  ALU result, passed to writeback.
REQ-007 SHALL have port rs2_data_in  input  32  store data.
REQ-008 SHALL have port load_in  input  1  load operation.
REQ-009 SHALL have port store_in  input  1  store operation.
REQ-010 SHALL have port load_store_size_in  input  2  size: 00 byte, 01 half, 10 word.
REQ-011 SHALL have port load_signed_in  input  1  sign-extend the load result.
REQ-012 SHALL have port bypass_memory_in  input  1  suppress bus access.
REQ-013 SHALL have port exception_in, ecause_in  input  1/4  upstream trap flag and cause.
REQ-014 SHALL have ports pc_in, next_pc_in, csr_data_in (32), write_select_in (2), rd_address_in (5), csr_address_in (12), csr_write_in, mret_in, wfi_in (1), all input; each is passed through to a matching *_out register.
REQ-015 SHALL have ports stall, invalidate  input  1  hazard-unit controls.
REQ-016 SHALL have ports mem_req, mem_write  output  1  bus request and direction.
REQ-017 SHALL have ports mem_address, mem_wdata  output  32  word-aligned address and lane-shifted store data.
REQ-018 SHALL have port mem_strobe  output  4  byte enables.
REQ-019 SHALL have ports mem_ready (1), mem_rdata (32)  input  bus completion and read word.
REQ-020 SHALL have port mem_busy  output  1  transaction outstanding; hazard unit stalls upstream.
REQ-021 SHALL have outputs valid_out, load_data_out (32), exception_out, ecause_out (4), plus the REQ-014 passthroughs.

Function
REQ-022 SHALL implement FSM IDLE/WAIT; mem_req=mem_busy=1 only in WAIT.
REQ-023 SHALL treat a beat as a bus op iff valid_in && (load_in||store_in) && !exception_in && !bypass_memory_in && aligned.
REQ-024 SHALL define aligned as: byte always; half addr[0]==0; word addr[1:0]==0.
REQ-025 SHALL flag misalignment as exception_out=1 with ecause 4 (load) or 6 (store); no bus op; exception_in takes priority.
REQ-026 SHALL, in IDLE with !stall, register all fields; a non-bus beat appears at valid_out next cycle, i.e. latency 1.
REQ-027 SHALL, in IDLE with !stall and a bus op, latch address/data/strobe, set valid_out=0, and enter WAIT.
REQ-028 SHALL, in WAIT, ignore stall and all *_in inputs, holding mem_* stable until mem_ready.
REQ-029 SHALL, on mem_ready in WAIT, set valid_out=1 (unless killed), capture load_data_out, and return to IDLE; a mem_ready in the first WAIT cycle is legal.
REQ-030 SHALL form load data from mem_rdata >> (8*addr[1:0]), truncated to size, then sign- or zero-extended.
REQ-031 SHALL generate strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Store data SHALL be replicated across lanes.
REQ-032 SHALL make valid_out=0 on the next edge when invalidate=1 in IDLE, regardless of stall.
REQ-033 SHALL, on invalidate in WAIT, set a kill flag; the bus op completes, but valid_out stays 0 and the kill flag clears on exit.
REQ-034 SHALL, in IDLE with stall=1, hold all outputs, including valid_out (except per REQ-032).

Reset
REQ-035 SHALL on reset enter IDLE and clear valid_out, exception_out, mem_req, mem_write, mem_busy, the kill flag, mem_strobe, ecause_out and load_data_out to 0, including mid-WAIT (request dropped).
REQ-036 SHALL leave passthrough data registers unreset, since they are qualified by valid_out.

Structure
REQ-037 SHALL place size encodings, ecause codes (2, 4, 6) and FSM state encoding in a shared package (pipeline_pkg).
REQ-038 SHALL isolate load alignment/extension in a combinational sub-module load_align.

Verification
REQ-039 Case lb: addr 0x1003, rdata 0x80AABBCC, signed -> load_data_out 0xFFFFFF80, strobe n/a, valid_out 1 cycle after mem_ready.
REQ-040 Case sh: addr 0x2002, rs2 0x0000BEEF -> mem_strobe 1100, mem_wdata 0xBEEFBEEF, mem_address 0x2000, mem_write 1.
REQ-041 Case lw misaligned: addr 0x3001 -> no mem_req, exception_out 1, ecause_out 4 after one cycle.
REQ-042 Case mem_ready held low 5 cycles: mem_busy 1 for 5 cycles and inputs changing during WAIT are ignored. Then invalidate in cycle 2 -> valid_out stays 0.
REQ-043 Case ALU op with stall toggling: valid_out mirrors accepted beats. Reset asserted mid-WAIT -> next cycle mem_req 0, valid_out 0.
